dti_pr_rsp_arb: RTL and testbench
=================================

# dti_pr_rsp_arb

Packet-atomic round-robin arbiter that shares one DTI response channel between `NUM_REQ` TBU-side requesters ahead of the response async-FIFO slave. Each input is a beat stream of payload/srcid/tgtid/qos/last. A grant is held from first beat to `last`, so packets never interleave. Output is registered through a 2-entry skid buffer and drives the async-FIFO slave's `rsp_*` inputs directly.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `STARVE_MAX`, 4: consecutive qos=1 packet grants allowed while a qos=0 requester waits (1..15).
- `clk`  in  1  clock.
- `rst`  in  1  reset; one clock, asynchronous assert, active-high.
- `in_valid`  in  NUM_REQ  per-requester beat valid.
- `in_payload`  in  NUM_REQ*PLD_W  flattened payload; requester i at bits [i*PLD_W +: PLD_W].
- `in_srcid`, `in_tgtid`  in  NUM_REQ*TBU_NUM_WIDTH each  flattened ids.
- `in_qos`  in  NUM_REQ  priority bit, sampled on the first beat only.
- `in_last`  in  NUM_REQ  final beat of packet.
- `in_ready`  out  NUM_REQ  per-requester accept; one-hot or zero.
- `out_valid`, `out_payload`[PLD_W], `out_srcid`, `out_tgtid`, `out_qos`, `out_last`  out  registered merged stream.
- `out_ready`  in  1  downstream accept, i.e. the async-FIFO `rsp_ready`.
- `arb_idle`  out  1  no lock held and skid buffer empty.

## Operation
- Beat transfer on a port: valid & ready in the same cycle. Inputs must hold valid/data stable until accepted.
- Unlocked: grant is combinational from current `in_valid`.
  - With QoS, candidates are the valid requesters with `in_qos`=1 if any exist, otherwise all valid requesters.
  - The winner is the first candidate at or after `rr_ptr`, wrapping.
- `in_ready[g]` = grant[g] & ~skid_full. At most one bit is set.
- First beat accepted with `in_last`=0: set `lock`=1, `lock_id`=g. While locked, only `lock_id` is granted, regardless of other valids.
- Beat accepted with `in_last`=1: clear `lock`. The next cycle arbitrates freshly, with no bubble.
- On each packet's first-beat acceptance, set `rr_ptr` = g+1 mod NUM_REQ. Single-beat packets (last on the first beat) update `rr_ptr` and never lock.
- Starvation counter `starve_cnt` (4 bits):
  - +1 when a qos=1 packet is granted while any qos=0 requester is valid.
  - Cleared when a qos=0 packet is granted.
  - At `starve_cnt`==STARVE_MAX, the next arbitration ignores qos (pure RR over all valids), then the counter clears.
- Skid buffer: 2 entries, FIFO order. `skid_full` is registered. Entry 0 drives the outputs. Pop on out_valid & out_ready; push on an accepted input beat. Simultaneous push and pop with 1 entry keeps 1 entry.
- Reset (including mid-packet): lock=0, rr_ptr=0, starve_cnt=0, skid flushed. Any partial packet is lost, and the upstream must reset together with this block.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_*` data=0, `arb_idle`=1.
- Latency: a beat accepted at cycle t appears on `out_*` at t+1.
- Throughput: 1 beat/cycle sustained while `out_ready`=1. Back-to-back packets from different requesters incur no idle cycle.
- `in_ready` depends on `in_valid`/`in_qos` combinationally, but not on `out_ready` (the skid buffer breaks that path).
- `out_ready` low for k cycles: at most 2 beats buffered, then `in_ready`=0. Resume with no beat lost or duplicated.
- Requester deasserting valid mid-packet while locked: the lock holds and the output stalls. There is no timeout.

## Configuration
- `DTI_PR_RSP_ARB_QOS_EN` defined: the qos-priority filter and starvation counter are present, as above.
- Not defined: pure round-robin; `in_qos` is forwarded to `out_qos` but ignored for arbitration; `starve_cnt` is not implemented.

## Structure
- In `dti_pack`:
  - `PLD_W` = CUSTOM_DATA_WIDTH+CUSTOM_KEEP_WIDTH (90).
  - the `TBU_NUM_WIDTH` reuse.
  - the beat struct typedef {payload, srcid, tgtid, qos, last}.
- Sub-module `dti_pr_skid_buf`: 2-entry valid/ready register slice, parameterised on beat width. It is reusable on other DTI channels.

## Test plan
- Reset, then a single-beat packet on req2 (srcid=2, tgtid=5, last=1) → `out_valid` at next cycle with identical fields; `rr_ptr`=3; `arb_idle`=1 one cycle after pop.
- req0 sends 3 beats while req1 is valid throughout → output order r0b0, r0b1, r0b2, r1…; no r1 beat inside the r0 packet.
- All 4 requesters valid, 1-beat packets, qos=0 → grants in order 0,1,2,3,0 at 1 beat/cycle.
- QoS on, STARVE_MAX=4: req0 qos=1 continuously, req1 qos=0 → 4 req0 packets, then 1 req1 packet, then repeat.
- `out_ready`=0 for 10 cycles during a 5-beat packet → exactly 2 beats buffered, `in_ready`=0; all 5 beats delivered in order after release.
- `rst` asserted mid-packet → all outputs return to reset values immediately; the next packet from any requester is arbitrated from rr_ptr=0.

Source files
------------

// File: rtl/dti_pack.sv
// Shared DTI channel definitions: payload/id widths and the beat record
// carried through the response arbiter and its skid buffer.
package dti_pack;

    localparam int CUSTOM_DATA_WIDTH = 80;
    localparam int CUSTOM_KEEP_WIDTH = 10;
    localparam int PLD_W             = CUSTOM_DATA_WIDTH + CUSTOM_KEEP_WIDTH;
    localparam int TBU_NUM_WIDTH     = 4;

    typedef struct packed {
        logic [PLD_W-1:0]         payload;
        logic [TBU_NUM_WIDTH-1:0] srcid;
        logic [TBU_NUM_WIDTH-1:0] tgtid;
        logic                     qos;
        logic                     last;
    } dti_beat_t;

    localparam int BEAT_W = $bits(dti_beat_t);

endpackage

// File: rtl/dti_pr_skid_buf.sv
// Two-entry valid/ready register slice. Entry 0 always drives the output;
// the full flag is a pure register so upstream ready never sees data_ready_i.
module dti_pr_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    output logic         full_o,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    input  logic         data_ready_i
);

    logic [1:0]   cnt_q, cnt_d;
    logic [W-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
    logic         push, pop;

    assign full_o  = (cnt_q == 2'd2);
    assign valid_o = (cnt_q != 2'd0);
    assign data_o  = ent0_q;
    assign push    = push_i & ~full_o;
    assign pop     = valid_o & data_ready_i;

    always_comb begin
        cnt_d  = cnt_q;
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        unique case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) ent0_d = push_data_i;
                else               ent1_d = push_data_i;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            // push is blocked when full, so a simultaneous push/pop only
            // happens with exactly one entry held
            2'b11:   ent0_d = push_data_i;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= 2'd0;
            ent0_q <= '0;
            ent1_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
        end
    end

endmodule

// File: rtl/dti_pr_rsp_arb.sv
// Packet-atomic round-robin arbiter for the DTI response channel.
// Define DTI_PR_RSP_ARB_QOS_EN to add the qos filter and starvation counter.
module dti_pr_rsp_arb
    import dti_pack::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               in_valid,
    input  logic [NUM_REQ*PLD_W-1:0]         in_payload,
    input  logic [NUM_REQ*TBU_NUM_WIDTH-1:0] in_srcid,
    input  logic [NUM_REQ*TBU_NUM_WIDTH-1:0] in_tgtid,
    input  logic [NUM_REQ-1:0]               in_qos,
    input  logic [NUM_REQ-1:0]               in_last,
    output logic [NUM_REQ-1:0]               in_ready,
    output logic                             out_valid,
    output logic [PLD_W-1:0]                 out_payload,
    output logic [TBU_NUM_WIDTH-1:0]         out_srcid,
    output logic [TBU_NUM_WIDTH-1:0]         out_tgtid,
    output logic                             out_qos,
    output logic                             out_last,
    input  logic                             out_ready,
    output logic                             arb_idle
);

    localparam int IDW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_cfg
        $error("dti_pr_rsp_arb: NUM_REQ or STARVE_MAX out of range");
    end

    dti_beat_t [NUM_REQ-1:0] beat;
    dti_beat_t               out_beat;
    logic                    lock_q, lock_d;
    logic [IDW-1:0]          lock_id_q, lock_id_d;
    logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]      cand, grant;
    logic [IDW-1:0]          gidx;
    logic                    gfound, accept, first, skid_full, starve_hit;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign beat[i] = '{payload: in_payload[i*PLD_W +: PLD_W],
                           srcid:   in_srcid[i*TBU_NUM_WIDTH +: TBU_NUM_WIDTH],
                           tgtid:   in_tgtid[i*TBU_NUM_WIDTH +: TBU_NUM_WIDTH],
                           qos:     in_qos[i],
                           last:    in_last[i]};
    end

`ifdef DTI_PR_RSP_ARB_QOS_EN
    logic [3:0] starve_cnt_q, starve_cnt_d;
    assign starve_hit = (starve_cnt_q == 4'(STARVE_MAX));

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (first) begin
            if (starve_hit || !in_qos[gidx])      starve_cnt_d = 4'd0;
            else if (|(in_valid & ~in_qos))       starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) starve_cnt_q <= 4'd0;
        else     starve_cnt_q <= starve_cnt_d;
    end
`else
    assign starve_hit = 1'b1;
`endif

    // Unlocked: pick first candidate at/after rr_ptr; locked: stay on lock_id
    always_comb begin
        cand = in_valid;
        if (!starve_hit && |(in_valid & in_qos)) cand = in_valid & in_qos;
        gfound = 1'b0;
        gidx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!gfound && cand[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
                gfound = 1'b1;
                gidx   = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
        if (lock_q) begin
            gfound = 1'b1;
            gidx   = lock_id_q;
        end
        grant = '0;
        if (gfound) grant[gidx] = 1'b1;
    end

    assign in_ready = grant & {NUM_REQ{~skid_full}};
    assign accept   = |(in_ready & in_valid);
    assign first    = accept & ~lock_q;

    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        rr_ptr_d  = rr_ptr_q;
        if (accept) begin
            lock_d    = ~beat[gidx].last;
            lock_id_d = gidx;
        end
        if (first) rr_ptr_d = (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    dti_pr_skid_buf #(.W(BEAT_W)) u_skid (
        .clk          (clk),
        .rst          (rst),
        .push_i       (accept),
        .push_data_i  (beat[gidx]),
        .full_o       (skid_full),
        .valid_o      (out_valid),
        .data_o       (out_beat),
        .data_ready_i (out_ready)
    );

    assign out_payload = out_beat.payload;
    assign out_srcid   = out_beat.srcid;
    assign out_tgtid   = out_beat.tgtid;
    assign out_qos     = out_beat.qos;
    assign out_last    = out_beat.last;
    assign arb_idle    = ~lock_q & ~out_valid;

endmodule

// File: tb/tb_dti_pr_rsp_arb.sv
// Bench for dti_pr_rsp_arb: directed scenarios then randomized traffic,
// checked each cycle against a packet/queue-level reference model.
module tb_dti_pr_rsp_arb;
    import dti_pack::*;

    localparam int N    = 4;
    localparam int SMAX = 4;
    localparam int TW   = TBU_NUM_WIDTH;
`ifdef DTI_PR_RSP_ARB_QOS_EN
    localparam bit QOS_EN = 1'b1;
`else
    localparam bit QOS_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N-1:0]         in_valid = '0, in_qos = '0, in_last = '0, in_ready;
    logic [N*PLD_W-1:0]   in_payload = '0;
    logic [N*TW-1:0]      in_srcid = '0, in_tgtid = '0;
    logic                 out_valid, out_qos, out_last, arb_idle;
    logic                 out_ready = 1'b1;
    logic [PLD_W-1:0]     out_payload;
    logic [TW-1:0]        out_srcid, out_tgtid;

    always #5 clk = ~clk;

    dti_pr_rsp_arb #(.NUM_REQ(N), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_payload(in_payload), .in_srcid(in_srcid),
        .in_tgtid(in_tgtid), .in_qos(in_qos), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_payload(out_payload), .out_srcid(out_srcid),
        .out_tgtid(out_tgtid), .out_qos(out_qos), .out_last(out_last),
        .out_ready(out_ready), .arb_idle(arb_idle)
    );

    dti_beat_t src_q [N][$];
    bit        pres  [N];
    dti_beat_t mq[$], log_q[$];
    int        m_lock, m_rr, m_starve;
    int        checks = 0, errors = 0;
    int        ordy_mode = 1;
    bit        gap_en = 1'b0;
    int        e[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_pkt(input int r, input int nb, input bit qos, input int tgt);
        for (int b = 0; b < nb; b++) begin
            dti_beat_t x;
            x.payload      = PLD_W'({$urandom(), $urandom(), $urandom()});
            x.payload[7:0] = 8'(b);
            x.srcid        = TW'(r);
            x.tgtid        = TW'(tgt);
            x.qos          = qos;
            x.last         = (b == nb - 1);
            src_q[r].push_back(x);
        end
    endtask

    function automatic bit busy();
        for (int i = 0; i < N; i++) if (src_q[i].size() > 0) return 1'b1;
        return mq.size() > 0;
    endfunction

    task automatic cycle();
        logic [N-1:0] v, q, cand, exp_rdy;
        dti_beat_t    hb, ob;
        int           g, idx;
        bit           full, hit;
        @(negedge clk);
        v = '0; q = '0;
        for (int i = 0; i < N; i++) begin
            if (!pres[i] && src_q[i].size() > 0 && (!gap_en || $urandom_range(0, 3) != 0))
                pres[i] = 1'b1;
            hb = pres[i] ? src_q[i][0] : '0;
            v[i] = pres[i];
            q[i] = hb.qos;
            in_last[i] = hb.last;
            in_payload[i*PLD_W +: PLD_W] = hb.payload;
            in_srcid[i*TW +: TW] = hb.srcid;
            in_tgtid[i*TW +: TW] = hb.tgtid;
        end
        in_valid  = v;
        in_qos    = q;
        out_ready = (ordy_mode == 2) ? ($urandom_range(0, 3) != 0) : (ordy_mode == 1);
        #1;
        // reference: who should be granted this cycle
        full = (mq.size() == 2);
        hit  = !QOS_EN || (m_starve == SMAX);
        g    = -1;
        if (m_lock >= 0) g = m_lock;
        else begin
            cand = (!hit && (v & q) != '0) ? (v & q) : v;
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (g < 0 && cand[idx]) g = idx;
            end
        end
        exp_rdy = '0;
        if (g >= 0 && !full) exp_rdy[g] = 1'b1;
        ob = '{payload: out_payload, srcid: out_srcid, tgtid: out_tgtid, qos: out_qos, last: out_last};
        chk("in_ready", 128'(in_ready), 128'(exp_rdy));
        chk("out_valid", 128'(out_valid), 128'(mq.size() > 0));
        chk("arb_idle", 128'(arb_idle), 128'(m_lock < 0 && mq.size() == 0));
        if (mq.size() > 0) chk("out_beat", 128'(ob), 128'(mq[0]));
        if (out_valid && out_ready) log_q.push_back(ob);
        if (mq.size() > 0 && out_ready) void'(mq.pop_front());
        if (exp_rdy != '0 && v[g]) begin
            hb = src_q[g][0];
            mq.push_back(hb);
            if (m_lock < 0) begin
                m_rr = (g + 1) % N;
                if (QOS_EN) begin
                    if (hit || !q[g])          m_starve = 0;
                    else if ((v & ~q) != '0)   m_starve = m_starve + 1;
                end
            end
            m_lock = hb.last ? -1 : g;
        end
        for (int i = 0; i < N; i++)
            if (v[i] && in_ready[i]) begin
                void'(src_q[i].pop_front());
                pres[i] = 1'b0;
            end
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (busy() && n < bound) begin
            cycle();
            n++;
        end
        chk("drain_done", 128'(busy()), 128'(0));
        cycle();
    endtask

    task automatic chk_order(input string tag);
        chk({tag, "_len"}, 128'(log_q.size()), 128'(e.size()));
        for (int i = 0; i < e.size() && i < log_q.size(); i++)
            chk(tag, 128'({log_q[i].srcid, log_q[i].payload[7:0]}), 128'(e[i]));
        log_q.delete();
        e.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            pres[i] = 1'b0;
        end
        in_valid = '0; in_qos = '0; in_last = '0;
        in_payload = '0; in_srcid = '0; in_tgtid = '0;
        out_ready = 1'b1;
        mq.delete(); log_q.delete();
        m_lock = -1; m_rr = 0; m_starve = 0;
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_payload", 128'(out_payload), 128'(0));
        chk("rst_out_fields", 128'({out_srcid, out_tgtid, out_qos, out_last}), 128'(0));
        chk("rst_arb_idle", 128'(arb_idle), 128'(1));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // single beat on req2, then all four: rr_ptr must have moved to 3
        do_reset();
        ordy_mode = 1; gap_en = 1'b0;
        add_pkt(2, 1, 1'b0, 5);
        drain(20);
        e.push_back(2 * 256);
        chk_order("single_req2");
        for (int r = 0; r < N; r++) add_pkt(r, 1, 1'b0, r);
        drain(20);
        for (int i = 0; i < N; i++) e.push_back(((3 + i) % N) * 256);
        chk_order("rr_after_req2");

        // packet atomicity: req1 waits for the whole req0 packet
        do_reset();
        add_pkt(0, 3, 1'b0, 1);
        add_pkt(1, 1, 1'b0, 1);
        drain(20);
        e.push_back(0); e.push_back(1); e.push_back(2); e.push_back(256);
        chk_order("atomic");

        // plain rotation 0,1,2,3,0
        do_reset();
        add_pkt(0, 1, 1'b0, 0); add_pkt(0, 1, 1'b0, 0);
        for (int r = 1; r < N; r++) add_pkt(r, 1, 1'b0, r);
        drain(20);
        for (int i = 0; i < 5; i++) e.push_back((i % N) * 256);
        chk_order("rotation");

        // qos pressure: req0 qos=1 continuous, req1 qos=0
        do_reset();
        for (int i = 0; i < 10; i++) add_pkt(0, 1, 1'b1, 2);
        for (int i = 0; i < 3; i++)  add_pkt(1, 1, 1'b0, 2);
        drain(40);
        for (int i = 0; i < 13; i++)
            if (QOS_EN) e.push_back((i == 4 || i == 9 || i == 12) ? 256 : 0);
            else        e.push_back((i == 1 || i == 3 || i == 5) ? 256 : 0);
        chk_order("qos_starve");

        // downstream stall during a 5-beat packet
        do_reset();
        ordy_mode = 0;
        add_pkt(1, 5, 1'b0, 3);
        repeat (10) cycle();
        chk("stall_in_ready", 128'(in_ready), 128'(0));
        chk("stall_out_valid", 128'(out_valid), 128'(1));
        chk("stall_accepted", 128'(src_q[1].size()), 128'(3));
        ordy_mode = 1;
        drain(20);
        for (int i = 0; i < 5; i++) e.push_back(256 + i);
        chk_order("stall_release");

        // reset in the middle of a locked packet
        do_reset();
        add_pkt(3, 4, 1'b0, 1);
        cycle(); cycle();
        do_reset();
        for (int r = 0; r < N; r++) add_pkt(r, 1, 1'b0, r);
        drain(20);
        for (int i = 0; i < N; i++) e.push_back(i * 256);
        chk_order("post_reset_rr");

        // randomized traffic with gaps and backpressure
        do_reset();
        ordy_mode = 2; gap_en = 1'b1;
        repeat (600) begin
            for (int r = 0; r < N; r++)
                if (src_q[r].size() < 4 && $urandom_range(0, 5) == 0)
                    add_pkt(r, $urandom_range(1, 4), 1'($urandom_range(0, 1)), $urandom_range(0, 15));
            cycle();
        end
        drain(2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
